// File: rtl/student_tlul_mem_responder.sv
// TL-UL memory responder: a word-addressed memory behind a TL-UL device port.
// It accepts Get/PutFullData/PutPartialData on channel A. It answers in
// acceptance order through a latency pipeline followed by a response FIFO.
// Credits drive a_ready, so the FIFO cannot overflow.

package tlul_pkg;

    localparam logic [2:0] OpPutFullData    = 3'h0;
    localparam logic [2:0] OpPutPartialData = 3'h1;
    localparam logic [2:0] OpGet            = 3'h4;
    localparam logic [2:0] OpAccessAck      = 3'h0;
    localparam logic [2:0] OpAccessAckData  = 3'h1;
    localparam logic [6:0] DUserDefault     = 7'h00;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [6:0]  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [6:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module student_tlul_mem_responder
    import tlul_pkg::*;
#(
    parameter logic [31:0] BaseAddr    = 32'h0,
    parameter int          Depth       = 256,
    parameter int          ReadLatency = 1,
    parameter int          RespDepth   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic [15:0] err_cnt_o
);

    localparam int          AW       = $clog2(Depth);
    localparam int          Stages   = ReadLatency - 1;
    localparam int          PW       = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam logic [31:0] WinBytes = 32'(Depth * 4);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } resp_t;

    // Wrapping pointer increment for a FIFO whose depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RespDepth - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    logic              ready_q, ready_d;
    logic [31:0]       mem_q [Depth];
    logic [31:0]       mem_d [Depth];
    logic [15:0]       err_cnt_q, err_cnt_d;
    resp_t             fifo_q [RespDepth];
    resp_t             fifo_d [RespDepth];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]       fifo_cnt_q, fifo_cnt_d;

    logic [31:0]       off_s;
    logic [AW-1:0]     idx_s;
    logic              err_s, is_get_s, is_put_s, op_ok_s;
    logic [15:0]       outstanding_s, pipe_cnt_s;
    logic              a_ready_s, accept_s, pop_s, push_vld_s;
    resp_t             acc_ent_s, push_ent_s, head_s;
    logic              unused_s;

    assign unused_s = ^{tl_i.a_param, tl_i.a_user};

    // Decode the channel A request and build its response entry.
    always_comb begin
        off_s    = tl_i.a_address - BaseAddr;
        idx_s    = off_s[AW+1:2];
        is_get_s = (tl_i.a_opcode == OpGet);
        is_put_s = (tl_i.a_opcode == OpPutFullData) || (tl_i.a_opcode == OpPutPartialData);
        op_ok_s  = is_get_s || is_put_s;
        err_s    = (off_s >= WinBytes) || (tl_i.a_address[1:0] != 2'b00) ||
                   (tl_i.a_size != 2'd2) || !op_ok_s ||
                   ((tl_i.a_opcode == OpPutFullData) && (tl_i.a_mask != 4'hF));
        outstanding_s = fifo_cnt_q + pipe_cnt_s;
        a_ready_s     = ready_q && (outstanding_s < 16'(RespDepth));
        accept_s      = tl_i.a_valid && a_ready_s;
        acc_ent_s.opcode = is_get_s ? OpAccessAckData : OpAccessAck;
        acc_ent_s.size   = tl_i.a_size;
        acc_ent_s.source = tl_i.a_source;
        acc_ent_s.error  = err_s;
        if (is_get_s && !err_s) begin
            acc_ent_s.data = mem_q[idx_s];
        end else begin
            acc_ent_s.data = 32'h0;
        end
    end

    // Byte-masked memory write for error-free Puts on the accept edge.
    always_comb begin
        mem_d = mem_q;
        if (accept_s && is_put_s && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                mem_d[idx_s][8*b +: 8] = tl_i.a_mask[b] ? tl_i.a_data[8*b +: 8]
                                                        : mem_q[idx_s][8*b +: 8];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Saturating error-response counter and post-reset ready enable.
    always_comb begin
        ready_d = 1'b1;
        if (accept_s && err_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    generate
        if (Stages > 0) begin : g_pipe
            logic  stg_vld_q [Stages];
            logic  stg_vld_d [Stages];
            resp_t stg_q     [Stages];
            resp_t stg_d     [Stages];

            // Shift accepted entries through the read-latency stages and count them.
            always_comb begin
                stg_vld_d[0] = accept_s;
                stg_d[0]     = acc_ent_s;
                for (int i = 1; i < Stages; i++) begin
                    stg_vld_d[i] = stg_vld_q[i-1];
                    stg_d[i]     = stg_q[i-1];
                end
                pipe_cnt_s = 16'h0;
                for (int i = 0; i < Stages; i++) begin
                    pipe_cnt_s = pipe_cnt_s + {15'h0, stg_vld_q[i]};
                end
            end

            // Latency stage registers; reset discards in-flight entries.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < Stages; i++) begin
                        stg_vld_q[i] <= 1'b0;
                        stg_q[i]     <= '0;
                    end
                end else begin
                    stg_vld_q <= stg_vld_d;
                    stg_q     <= stg_d;
                end
            end

            assign push_vld_s = stg_vld_q[Stages-1];
            assign push_ent_s = stg_q[Stages-1];
        end else begin : g_nopipe
            assign push_vld_s = accept_s;
            assign push_ent_s = acc_ent_s;
            assign pipe_cnt_s = 16'h0;
        end
    endgenerate

    // Response FIFO bookkeeping: simultaneous push and pop keeps the count.
    always_comb begin
        pop_s  = (fifo_cnt_q != 16'h0) && tl_i.d_ready;
        fifo_d = fifo_q;
        if (push_vld_s) begin
            fifo_d[wr_ptr_q] = push_ent_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {15'h0, push_vld_s} - {15'h0, pop_s};
    end

    // Channel D is driven from the FIFO head, a_ready from the credit count.
    always_comb begin
        head_s          = fifo_q[rd_ptr_q];
        tl_o.d_valid    = (fifo_cnt_q != 16'h0);
        tl_o.d_opcode   = head_s.opcode;
        tl_o.d_param    = 3'h0;
        tl_o.d_size     = head_s.size;
        tl_o.d_source   = head_s.source;
        tl_o.d_sink     = 1'b0;
        tl_o.d_data     = head_s.data;
        tl_o.d_user     = DUserDefault;
        tl_o.d_error    = head_s.error;
        tl_o.a_ready    = a_ready_s;
        err_cnt_o       = err_cnt_q;
    end

    // State registers; reset clears memory, FIFO, counter and ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q    <= 1'b0;
            err_cnt_q  <= 16'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= 16'h0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= 32'h0;
            end
            for (int i = 0; i < RespDepth; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ready_q    <= ready_d;
            err_cnt_q  <= err_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            mem_q      <= mem_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule

// File: tb/tb_student_tlul_mem_responder.sv
// Scoreboard bench for student_tlul_mem_responder.
module tb_student_tlul_mem_responder;
    import tlul_pkg::*;

    localparam logic [31:0] BASE  = 32'h0;
    localparam int          DEPTH = 256;
    localparam int          RL    = 1;
    localparam int          RD    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic [15:0] err_cnt;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    int          acc_cnt = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    student_tlul_mem_responder #(
        .BaseAddr(BASE), .Depth(DEPTH), .ReadLatency(RL), .RespDepth(RD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o), .err_cnt_o(err_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: compare the FIFO head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tl_o.d_valid) begin
            check_eq("resp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                if (tl_i.d_ready) begin
                    check_eq("d_opcode", tl_o.d_opcode, sb[0].op);
                    check_eq("d_size",   tl_o.d_size,   sb[0].size);
                    check_eq("d_source", tl_o.d_source, sb[0].src);
                    check_eq("d_data",   tl_o.d_data,   sb[0].data);
                    check_eq("d_error",  tl_o.d_error,  sb[0].err);
                    check_eq("d_consts", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 64'd0);
                    void'(sb.pop_front());
                end else begin
                    check_eq("stall_data",   tl_o.d_data,   sb[0].data);
                    check_eq("stall_source", tl_o.d_source, sb[0].src);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        exp_t        e;
        logic [31:0] off;
        logic        err;
        bit          got;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = size;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_eq("a_ready_timeout", tl_o.a_ready, 1'b1);
            tl_i.a_valid = 1'b0;
            return;
        end
        off = addr - BASE;
        err = (off >= 32'(DEPTH * 4)) || (addr[1:0] != 2'b00) || (size != 2'd2) ||
              !((op == 3'h0) || (op == 3'h1) || (op == 3'h4)) ||
              ((op == 3'h0) && (mask != 4'hF));
        e.op   = (op == 3'h4) ? 3'h1 : 3'h0;
        e.size = size;
        e.src  = src;
        e.err  = err;
        e.data = (op == 3'h4 && !err) ? model[off[9:2]] : 32'h0;
        if (!err && op != 3'h4) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) model[off[9:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
        if (err) err_exp++;
        sb.push_back(e);
        acc_cnt++;
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
    endtask

    task automatic drain();
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check_eq("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t0;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tl_o", tl_o, '0);
        check_eq("reset_err_cnt", err_cnt, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("a_ready_before_clk", tl_o.a_ready, 1'b0);
        @(posedge clk);
        #1;
        check_eq("a_ready_after_release", tl_o.a_ready, 1'b1);

        // Word round trip and latency
        send(3'h0, BASE + 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'd3);
        drain();
        send(3'h4, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd3);
        lat = 0;
        while (!tl_o.d_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("get_latency", lat + 1, RL);
        drain();

        // Byte masking, including an empty mask
        send(3'h0, BASE + 32'h20, 2'd2, 4'hF, 32'hAABBCCDD, 8'd4);
        send(3'h1, BASE + 32'h20, 2'd2, 4'b0101, 32'h11223344, 8'd5);
        send(3'h4, BASE + 32'h20, 2'd2, 4'hF, 32'h0, 8'd6);
        send(3'h1, BASE + 32'h20, 2'd2, 4'h0, 32'hFFFFFFFF, 8'd7);
        send(3'h4, BASE + 32'h20, 2'd2, 4'hF, 32'h0, 8'd8);
        send(3'h0, BASE + 32'h30, 2'd2, 4'hF, 32'h55AA1234, 8'd9);
        drain();
        check_eq("masked_model", model[8], 32'hAA22CC44);

        // Backpressure with two credits
        tl_i.d_ready = 1'b0;
        acc_cnt = 0;
        send(3'h4, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd1);
        send(3'h4, BASE + 32'h20, 2'd2, 4'hF, 32'h0, 8'd2);
        check_eq("a_ready_full", tl_o.a_ready, 1'b0);
        fork
            send(3'h4, BASE + 32'h30, 2'd2, 4'hF, 32'h0, 8'd5);
            begin
                repeat (4) @(posedge clk);
                #1;
                check_eq("third_waits", acc_cnt, 2);
                tl_i.d_ready = 1'b1;
            end
        join
        drain();

        // Error responses
        send(3'h4, BASE + 32'(DEPTH * 4), 2'd2, 4'hF, 32'h0, 8'd10);
        send(3'h4, BASE + 32'h2, 2'd2, 4'hF, 32'h0, 8'd11);
        send(3'h4, BASE + 32'h10, 2'd1, 4'hF, 32'h0, 8'd12);
        send(3'h5, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd13);
        send(3'h0, BASE + 32'h10, 2'd2, 4'h7, 32'h01020304, 8'd14);
        drain();
        check_eq("err_cnt", err_cnt, 16'(err_exp));
        check_eq("err_cnt_five", err_cnt, 16'd5);
        send(3'h4, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd15);
        drain();

        // Streaming at one accept per cycle
        t0 = cyc;
        for (int i = 0; i < 16; i++)
            send(3'h0, BASE + 32'h100 + 32'(4 * i), 2'd2, 4'hF, 32'h0F0F0000 + 32'(i * 17), 8'(i));
        check_eq("stream_put_cycles", cyc - t0, 16);
        t0 = cyc;
        for (int i = 0; i < 16; i++)
            send(3'h4, BASE + 32'h100 + 32'(4 * i), 2'd2, 4'hF, 32'h0, 8'(i + 32));
        check_eq("stream_get_cycles", cyc - t0, 16);
        drain();

        // Reset while responses are stalled
        tl_i.d_ready = 1'b0;
        send(3'h4, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd1);
        send(3'h4, BASE + 32'h100, 2'd2, 4'hF, 32'h0, 8'd2);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_d_valid", tl_o.d_valid, 1'b0);
        check_eq("rst_a_ready", tl_o.a_ready, 1'b0);
        check_eq("rst_err_cnt", err_cnt, 16'h0);
        sb.delete();
        err_exp = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rel_a_ready_low", tl_o.a_ready, 1'b0);
        @(posedge clk);
        #1;
        check_eq("rel_a_ready_high", tl_o.a_ready, 1'b1);
        tl_i.d_ready = 1'b1;
        send(3'h4, BASE + 32'h10, 2'd2, 4'hF, 32'h0, 8'd3);
        send(3'h4, BASE + 32'h100, 2'd2, 4'hF, 32'h0, 8'd4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
